// File: rtl/halfband_dec2_if.sv
// Sample stream into and decimated stream out of the halfband decimator.
// in/in_en come from the CIC side; out/out_vld/busy/ovf report back.
interface halfband_dec2_if #(
  parameter int IW = 15,
  parameter int OW = 15
);
  logic                 in_en;
  logic signed [IW-1:0] in;
  logic signed [OW-1:0] out;
  logic                 out_vld;
  logic                 busy;
  logic                 ovf;

  modport master (
    output in_en,
    output in,
    input  out,
    input  out_vld,
    input  busy,
    input  ovf
  );

  modport slave (
    input  in_en,
    input  in,
    output out,
    output out_vld,
    output busy,
    output ovf
  );
endinterface

// File: rtl/halfband_dec2.sv
// Decimate-by-2 halfband FIR h={-1,0,9,16,9,0,-1}/32 on one shared MAC; HALFBAND_DEC2_SAT_EN selects output clipping over wrap.
// Latency: out/out_vld 4 clocks after the edge accepting the second sample of a pair.
// No backpressure: samples always shift in; a start arriving while busy is dropped and sets sticky ovf.
module halfband_dec2 #(
  parameter int IW = 15,
  parameter int OW = 15
) (
  input  logic           clk,
  input  logic           res,
  halfband_dec2_if.slave bus
);

  localparam int PW = IW + 1;
  localparam int AW = IW + 8;

  typedef enum logic [2:0] {
    IDLE,
    MAC0,
    MAC1,
    MAC2,
    OUTS
  } state_t;

  logic signed [IW-1:0] dly [6];
  logic signed [IW-1:0] p0, p2, p3, p4, p6;
  logic                 phase;
  state_t               state, state_nxt;
  logic signed [AW-1:0] acc, acc_nxt;
  logic signed [PW-1:0] pre06, pre24;
  logic signed [AW-1:0] pre06_x, pre24_x, p3_x;
  logic signed [AW-1:0] mul9, mul16;
  logic signed [OW-1:0] out_q, out_nxt;
  logic                 out_vld_q;
  logic                 ovf_q;
  logic                 busy;
  logic                 start;
  logic                 start_ok;

  assign busy     = (state == MAC0) || (state == MAC1) || (state == MAC2);
  assign start    = bus.in_en & phase;
  assign start_ok = start & ~busy;

  // s0 is the incoming sample itself, so only s1..s6 of the old window need storage
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      phase <= 1'b0;
      for (int i = 0; i < 6; i++) dly[i] <= '0;
    end else if (bus.in_en) begin
      phase  <= ~phase;
      dly[0] <= bus.in;
      for (int i = 1; i < 6; i++) dly[i] <= dly[i-1];
    end
  end

  // Snapshot holds only the taps with nonzero coefficients
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      p0 <= '0;
      p2 <= '0;
      p3 <= '0;
      p4 <= '0;
      p6 <= '0;
    end else if (start_ok) begin
      p0 <= bus.in;
      p2 <= dly[1];
      p3 <= dly[2];
      p4 <= dly[3];
      p6 <= dly[5];
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ovf_q <= 1'b0;
    end else if (start && busy) begin
      ovf_q <= 1'b1;
    end
  end

  assign pre06   = {p0[IW-1], p0} + {p6[IW-1], p6};
  assign pre24   = {p2[IW-1], p2} + {p4[IW-1], p4};
  assign pre06_x = {{(AW-PW){pre06[PW-1]}}, pre06};
  assign pre24_x = {{(AW-PW){pre24[PW-1]}}, pre24};
  assign p3_x    = {{(AW-IW){p3[IW-1]}}, p3};
  assign mul9    = (pre24_x <<< 3) + pre24_x;
  assign mul16   = p3_x <<< 4;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    case (state)
      IDLE: begin
        if (start) state_nxt = MAC0;
      end
      MAC0: begin
        acc_nxt   = -pre06_x;
        state_nxt = MAC1;
      end
      MAC1: begin
        acc_nxt   = acc + mul9;
        state_nxt = MAC2;
      end
      MAC2: begin
        acc_nxt   = acc + mul16;
        state_nxt = OUTS;
      end
      OUTS: begin
        state_nxt = start ? MAC0 : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef HALFBAND_DEC2_SAT_EN
  localparam logic signed [AW-1:0] RMAX = AW'((1 <<< (OW-1)) - 1);
  localparam logic signed [AW-1:0] RMIN = AW'(-(1 <<< (OW-1)));

  logic signed [AW-1:0] rnd;

  assign rnd = (acc + AW'(16)) >>> 5;

  always_comb begin
    if (rnd > RMAX) begin
      out_nxt = {1'b0, {(OW-1){1'b1}}};
    end else if (rnd < RMIN) begin
      out_nxt = {1'b1, {(OW-1){1'b0}}};
    end else begin
      out_nxt = rnd[OW-1:0];
    end
  end
`else
  assign out_nxt = OW'((acc + AW'(16)) >>> 5);
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= IDLE;
      acc       <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      out_vld_q <= (state == OUTS);
      if (state == OUTS) out_q <= out_nxt;
    end
  end

  assign bus.out     = out_q;
  assign bus.out_vld = out_vld_q;
  assign bus.busy    = busy;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_halfband_dec2.sv
// Directed bench for halfband_dec2: scoreboard queue of hand-computed outputs and their due cycles.
module tb_halfband_dec2;

`ifdef HALFBAND_DEC2_SAT_EN
  localparam int BIG_4TH = 16383;
`else
  localparam int BIG_4TH = -14337;
`endif

  bit   clk;
  logic res;
  int   cyc;
  int   n_chk;
  int   n_fail;
  int   exp_q[$];
  int   cyc_q[$];

  halfband_dec2_if #(.IW(15), .OW(15)) bus ();

  halfband_dec2 #(.IW(15), .OW(15)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (res === 1'b1 && bus.out_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out_vld: got out_vld=1 out=%0d at cycle %0d, required no output",
                   int'(bus.out), cyc);
        end else begin
          int e;
          int c;
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          chk("out_value", int'(bus.out), e);
          chk("out_cycle", cyc, c);
        end
      end
    end
  endtask

  task automatic send(input int v, input bit has_exp, input int ev, input int gap);
    logic signed [14:0] vv;
    vv         = 15'(v);
    bus.in     = vv;
    bus.in_en  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_en = 1'b0;
    if (has_exp) begin
      exp_q.push_back(ev);
      cyc_q.push_back(cyc + 4);
    end
    repeat (gap - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic feed(input int xs[$], input int ex[$]);
    for (int i = 0; i < xs.size(); i++) begin
      bit has;
      has = (i % 2 == 1);
      send(xs[i], has, has ? ex[i/2] : 0, 4);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
      cyc_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_out"}, int'(bus.out), 0);
    chk({tag, "_out_vld"}, int'(bus.out_vld), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_ovf"}, int'(bus.ovf), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    bus.in_en = 1'b0;
    res       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b1;
    check_idle(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by 2 ms, required completion");
    $fatal(1);
  end

  initial begin
    int xs[$];
    int ex[$];
    res       = 1'b0;
    bus.in_en = 1'b0;
    bus.in    = '0;
    fork
      monitor();
    join_none

    // Constant 1000: ramp-up from zero history, then settles at 1000
    do_reset("reset");
    xs = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    ex = '{-31, 750, 1031, 1000};
    feed(xs, ex);
    bus.in    = 15'sd1000;
    bus.in_en = 1'b1;
    @(posedge clk);
    #1;
    bus.in_en = 1'b0;
    exp_q.push_back(1000);
    cyc_q.push_back(cyc + 4);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("busy_in_mac2", int'(bus.busy), 1);
    @(posedge clk);
    @(negedge clk);
    chk("busy_in_out_state", int'(bus.busy), 0);
    drain();

    // Impulse at odd index
    do_reset("reset2");
    xs = '{0, 1000, 0, 0, 0, 0, 0, 0, 0, 0};
    ex = '{-31, 281, 281, -31, 0};
    feed(xs, ex);
    drain();

    // Impulse at even index
    do_reset("reset3");
    xs = '{1000, 0, 0, 0, 0, 0, 0, 0};
    ex = '{0, 500, 0, 0};
    feed(xs, ex);
    drain();

    // Full-scale pattern: 4th output exceeds the 15-bit range
    do_reset("reset4");
    xs = '{0, -16384, 0, 16383, 16383, 16383, 0, -16384};
    ex = '{512, -5120, -512, BIG_4TH};
    feed(xs, ex);
    drain();

    // Overrun: second start two clocks after the first is dropped
    do_reset("reset5");
    send(0, 1'b0, 0, 1);
    send(1000, 1'b1, -31, 1);
    chk("ovf_before_overrun", int'(bus.ovf), 0);
    send(0, 1'b0, 0, 1);
    send(0, 1'b0, 0, 4);
    chk("ovf_after_overrun", int'(bus.ovf), 1);
    send(0, 1'b0, 0, 4);
    send(0, 1'b1, 281, 4);
    drain();
    chk("ovf_sticky", int'(bus.ovf), 1);

    // Reset during MAC1 with PHASE=1 and OVF=1
    send(700, 1'b0, 0, 1);
    bus.in    = 15'sd2000;
    bus.in_en = 1'b1;
    @(posedge clk);
    #1;
    bus.in = 15'sd0;
    @(posedge clk);
    #1;
    bus.in_en = 1'b0;
    chk("busy_before_reset", int'(bus.busy), 1);
    res = 1'b0;
    @(posedge clk);
    #1;
    res = 1'b1;
    check_idle("after_midmac_reset");
    repeat (8) @(posedge clk);
    #1;
    send(500, 1'b0, 0, 4);
    send(500, 1'b1, -16, 4);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
